ir_cmd_scheduler: RTL
=====================

Name: ir_cmd_scheduler

Overview:
- Sits between the IR frame decoder and the tester's main control FSM.
- Accepts decoded 32-bit NEC frames and filters them by custom (address) code.
- Suppresses auto-repeat of a held key with a hold-off timer.
- Queues accepted key codes in a small FIFO and presents them to the consumer through a valid/ready handshake.

Parameters:
- CUSTOM_CODE, 16'h00FF: required value of frame bits [15:0]; other frames are dropped.
- HOLDOFF_CYC, 15000000: hold-off window in iCLK cycles (300 ms at 50 MHz) for a repeated identical key.
- FIFO_DEPTH, 4: key FIFO entries; must be a power of two, 2..16.

Ports:
- iCLK  in  1  system clock, 50 MHz
- iRST_n  in  1  asynchronous active-low reset
- iDATA_READY  in  1  one-cycle pulse, frame valid on iDATA
- iDATA  in  32  decoded frame; [15:0] custom code, [23:16] key, [31:24] inverted key (already checked upstream)
- iFLUSH  in  1  synchronous clear of FIFO and hold-off state
- oCMD_VALID  out  1  FIFO head valid
- oCMD  out  8  key code at FIFO head
- iCMD_READY  in  1  consumer accepts head when high with oCMD_VALID
- oOVERFLOW  out  1  one-cycle pulse, accepted frame lost because FIFO full
- oLEVEL  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: all registers clear; oCMD_VALID=0, oCMD=0, oOVERFLOW=0, oLEVEL=0, ingest FSM=IDLE, holdoff count=0, last_key=0.
- Reset is honoured mid-operation: any captured frame and the FIFO contents are discarded.
- Ingest FSM states: IDLE, FILTER.
- IDLE: on iDATA_READY, register iDATA[23:0] -> FILTER. While in FILTER, iDATA_READY is ignored (frame lost, no flag).
- FILTER, single cycle, then always back to IDLE. Decision order:
  - 1. captured[15:0] != CUSTOM_CODE -> drop silently.
  - 2. key == last_key and holdoff count != 0 -> drop, reload holdoff count to HOLDOFF_CYC (a held key stays suppressed).
  - 3. FIFO full and no pop this cycle -> drop, pulse oOVERFLOW next cycle; last_key and holdoff are not updated.
  - 4. Otherwise push key, last_key <= key, holdoff count <= HOLDOFF_CYC.
- Holdoff counter:
  - Width $clog2(HOLDOFF_CYC+1).
  - Decrements by 1 per cycle while nonzero; saturates at 0.
  - A different key bypasses hold-off regardless of count.
- Latency: iDATA_READY in cycle T -> FILTER in T+1 -> oCMD_VALID high in T+2 if the FIFO was empty.
- FIFO:
  - First-word-fall-through; oCMD is the registered head, stable while oCMD_VALID=1 and iCMD_READY=0.
  - Pop on oCMD_VALID && iCMD_READY.
  - Simultaneous push and pop: both occur, oLEVEL unchanged; when full, the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is one bit wider so full (oLEVEL==FIFO_DEPTH) and empty (0) are distinct.
  - iCMD_READY with empty FIFO: no effect.
- iFLUSH:
  - Next cycle: FIFO empty, oCMD_VALID=0, holdoff count=0, last_key=0, FSM=IDLE.
  - Flush wins over a simultaneous push or pop.

Optional Feature:
- Macro: IR_CMD_DROP_CNT_EN.
- When defined: adds output oDROP_CNT[7:0], a saturating count (stops at 255) of frames dropped for reasons 1–3 above. It clears on reset and on iFLUSH.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package ir_pkg holds:
  - NEC field bit-position constants (custom code [15:0], key [23:16], inverse [31:24]).
  - The ingest-state typedef (IDLE, FILTER).
  - Named key-code constants used by the main control FSM (digits 0–9, OK, CLEAR).
- One sub-module, ir_key_fifo: parameterised-depth 8-bit FWFT FIFO with push, pop, flush, level, full and empty. Filter, hold-off and FSM stay in ir_cmd_scheduler.

Test Plan:
- Single frame 32'hE51AFF00 (key 8'h1A, custom 16'hFF00) with CUSTOM_CODE=16'hFF00 → oCMD_VALID high 2 cycles after the pulse, oCMD=8'h1A, oLEVEL=1. iCMD_READY held high for one cycle → oCMD_VALID=0, oLEVEL=0.
- Same frame, custom code 16'h1234 → no push, oLEVEL stays 0 (oDROP_CNT=1 when IR_CMD_DROP_CNT_EN is defined).
- HOLDOFF_CYC=100:
  - key 8'h05 accepted;
  - same key again 50 cycles later → dropped;
  - again 140 cycles after the first (reload at 50, so still suppressed) → dropped;
  - key 8'h06 at cycle 160 → accepted immediately.
- FIFO_DEPTH=4, iCMD_READY=0, five distinct keys → oLEVEL=4; the fifth pulses oOVERFLOW one cycle; the head still shows the first key.
- Full FIFO with iCMD_READY=1 in the FILTER cycle of a new key → pop and push both happen, oLEVEL stays 4, the new key is at the tail.
- iRST_n asserted low asynchronously mid-FILTER with 3 keys queued → all outputs 0 immediately; after release, the next frame is accepted normally with latency 2.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared definitions for the IR command path: NEC frame field positions,
// ingest state type and the key codes consumed by the main control FSM.
package ir_pkg;

  localparam int unsigned NEC_CUSTOM_LSB = 0;
  localparam int unsigned NEC_CUSTOM_MSB = 15;
  localparam int unsigned NEC_KEY_LSB    = 16;
  localparam int unsigned NEC_KEY_MSB    = 23;
  localparam int unsigned NEC_INV_LSB    = 24;
  localparam int unsigned NEC_INV_MSB    = 31;

  typedef enum logic {
    IDLE,
    FILTER
  } ingest_state_e;

  localparam logic [7:0] KEY_0     = 8'h16;
  localparam logic [7:0] KEY_1     = 8'h0C;
  localparam logic [7:0] KEY_2     = 8'h18;
  localparam logic [7:0] KEY_3     = 8'h5E;
  localparam logic [7:0] KEY_4     = 8'h08;
  localparam logic [7:0] KEY_5     = 8'h1C;
  localparam logic [7:0] KEY_6     = 8'h5A;
  localparam logic [7:0] KEY_7     = 8'h42;
  localparam logic [7:0] KEY_8     = 8'h52;
  localparam logic [7:0] KEY_9     = 8'h4A;
  localparam logic [7:0] KEY_OK    = 8'h40;
  localparam logic [7:0] KEY_CLEAR = 8'h44;

  function automatic logic [7:0] nec_key(input logic [23:0] frame);
    return frame[NEC_KEY_MSB:NEC_KEY_LSB];
  endfunction

  function automatic logic [15:0] nec_custom(input logic [23:0] frame);
    return frame[NEC_CUSTOM_MSB:NEC_CUSTOM_LSB];
  endfunction

endpackage

// File: rtl/ir_key_fifo.sv
// First-word-fall-through FIFO of 8-bit key codes; DEPTH must be a power of two.
module ir_key_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [7:0]                 data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = cnt_q;

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Filters decoded NEC frames by custom code, suppresses held-key repeats and
// queues keys for the control FSM. Define IR_CMD_DROP_CNT_EN to add oDROP_CNT.
module ir_cmd_scheduler
  import ir_pkg::*;
#(
  parameter logic [15:0] CUSTOM_CODE = 16'h00FF,
  parameter int unsigned HOLDOFF_CYC = 15000000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                        iCLK,
  input  logic                        iRST_n,
  input  logic                        iDATA_READY,
  input  logic [31:0]                 iDATA,
  input  logic                        iFLUSH,
  output logic                        oCMD_VALID,
  output logic [7:0]                  oCMD,
  input  logic                        iCMD_READY,
  output logic                        oOVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] oLEVEL
`ifdef IR_CMD_DROP_CNT_EN
  ,
  output logic [7:0]                  oDROP_CNT
`endif
);

  localparam int unsigned HW = $clog2(HOLDOFF_CYC + 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLDOFF_CYC);

  ingest_state_e state_q, state_d;
  logic [23:0]   cap_q, cap_d;
  logic [7:0]    last_key_q, last_key_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          ovf_q, ovf_d;
  logic          push, drop, fifo_full, fifo_empty, pop;
  logic [7:0]    key;

  // Inverted-key byte is already validated by the decoder.
  logic unused_inv_bits;
  assign unused_inv_bits = ^iDATA[NEC_INV_MSB:NEC_INV_LSB];

  assign key = nec_key(cap_q);
  assign pop = !fifo_empty && iCMD_READY;

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    last_key_d = last_key_q;
    hold_d     = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
    ovf_d      = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iDATA_READY) begin
          cap_d   = iDATA[23:0];
          state_d = FILTER;
        end
      end
      FILTER: begin
        state_d = IDLE;
        if (nec_custom(cap_q) != CUSTOM_CODE) begin
          drop = 1'b1;
        end else if (key == last_key_q && hold_q != '0) begin
          drop   = 1'b1;
          hold_d = HOLD_RELOAD;
        end else if (fifo_full && !pop) begin
          drop  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          push       = 1'b1;
          last_key_d = key;
          hold_d     = HOLD_RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides any decision made in the same cycle.
    if (iFLUSH) begin
      state_d    = IDLE;
      last_key_d = '0;
      hold_d     = '0;
      ovf_d      = 1'b0;
      push       = 1'b0;
      drop       = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      last_key_q <= '0;
      hold_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      last_key_q <= last_key_d;
      hold_q     <= hold_d;
      ovf_q      <= ovf_d;
    end
  end

  ir_key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iCLK),
    .rst_ni  (iRST_n),
    .push_i  (push),
    .data_i  (key),
    .pop_i   (iCMD_READY),
    .flush_i (iFLUSH),
    .data_o  (oCMD),
    .level_o (oLEVEL),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign oCMD_VALID = !fifo_empty;
  assign oOVERFLOW  = ovf_q;

`ifdef IR_CMD_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (iFLUSH)                              drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 8'hFF)    drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign oDROP_CNT = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
